// File: rtl/vend_pkg.sv
// vend_pkg: shared encodings for the vending controller -- state enum,
// coin_code / disp_coin encodings, coin values and sel_error codes.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        LOOKUP,
        VEND,
        CHANGE
    } state_t;

    typedef enum logic [2:0] {
        COIN_NICKEL  = 3'd0,
        COIN_DIME    = 3'd1,
        COIN_QUARTER = 3'd2,
        COIN_FIFTY   = 3'd3,
        COIN_DOLLAR  = 3'd4,
        COIN_FIVE    = 3'd5
    } coin_code_t;

    typedef enum logic [1:0] {
        DISP_NICKEL,
        DISP_DIME,
        DISP_QUARTER,
        DISP_DOLLAR
    } disp_coin_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_SOLD_OUT,
        SEL_INSUFFICIENT,
        SEL_INVALID
    } sel_error_t;

    localparam logic [9:0] VAL_NICKEL  = 10'd5;
    localparam logic [9:0] VAL_DIME    = 10'd10;
    localparam logic [9:0] VAL_QUARTER = 10'd25;
    localparam logic [9:0] VAL_FIFTY   = 10'd50;
    localparam logic [9:0] VAL_DOLLAR  = 10'd100;
    localparam logic [9:0] VAL_FIVE    = 10'd500;

    // Highest valid item index (C3).
    localparam logic [3:0] LAST_ITEM = 4'd8;

    function automatic logic coinIsValid(input logic [2:0] code);
        return code <= COIN_FIVE;
    endfunction

    // Cents for an inserted coin/bill; codes 6 and 7 carry no value.
    function automatic logic [9:0] coinValue(input logic [2:0] code);
        case (code)
            COIN_NICKEL:  return VAL_NICKEL;
            COIN_DIME:    return VAL_DIME;
            COIN_QUARTER: return VAL_QUARTER;
            COIN_FIFTY:   return VAL_FIFTY;
            COIN_DOLLAR:  return VAL_DOLLAR;
            COIN_FIVE:    return VAL_FIVE;
            default:      return 10'd0;
        endcase
    endfunction

    // Cents for a coin paid out by the change dispenser.
    function automatic logic [9:0] dispValue(input disp_coin_t coin);
        case (coin)
            DISP_NICKEL:  return VAL_NICKEL;
            DISP_DIME:    return VAL_DIME;
            DISP_QUARTER: return VAL_QUARTER;
            default:      return VAL_DOLLAR;
        endcase
    endfunction

endpackage

// File: rtl/change_unit.sv
// change_unit: holds the change still owed and pays it out greedily
// (100, 25, 10, 5) one coin per disp_valid/disp_ready handshake.
// load latches the amount, start begins paying, done flags completion.
module change_unit
    import vend_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          cancelReset,
    input  logic          load,
    input  logic [CW-1:0] loadValue,
    input  logic          start,
    input  logic          disp_ready,
    output logic          disp_valid,
    output logic [1:0]    disp_coin,
    output logic [CW-1:0] remaining,
    output logic          done
);

    disp_coin_t coinSel;
    logic       active;

    function automatic disp_coin_t pickCoin(input logic [CW-1:0] amt);
        if (amt >= CW'(VAL_DOLLAR))       return DISP_DOLLAR;
        else if (amt >= CW'(VAL_QUARTER)) return DISP_QUARTER;
        else if (amt >= CW'(VAL_DIME))    return DISP_DIME;
        else                              return DISP_NICKEL;
    endfunction

    assign disp_coin = coinSel;
    assign done      = active && !disp_valid && (remaining == '0);

    // Payout loop: present a coin, hold it until accepted, subtract, repeat.
    always_ff @(posedge clk or posedge cancelReset) begin
        if (cancelReset) begin
            remaining  <= '0;
            active     <= 1'b0;
            disp_valid <= 1'b0;
            coinSel    <= DISP_NICKEL;
        end else begin
            if (load) begin
                remaining <= loadValue;
            end
            if (start) begin
                active <= 1'b1;
            end else if (disp_valid) begin
                if (disp_ready) begin
                    remaining  <= remaining - CW'(dispValue(coinSel));
                    disp_valid <= 1'b0;
                end
            end else if (active) begin
                if (remaining == '0) begin
                    active <= 1'b0;
                end else if (remaining < CW'(VAL_NICKEL)) begin
                    // A residue below the smallest coin cannot be paid; drop it.
                    remaining <= '0;
                end else begin
                    disp_valid <= 1'b1;
                    coinSel    <= pickCoin(remaining);
                end
            end
        end
    end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: clocked sequencer for the 3x3 vending machine.
// Tracks credit, looks up prices, drives the vend motor handshake and hands
// owed change to change_unit.
// Optional feature macro: PRICE_PREVIEW_EN (price preview on an idle selection).
module vend_controller
    import vend_pkg::*;
#(
    parameter int CW          = 10,
    parameter int MAX_CREDIT  = 500,
    parameter int PREVIEW_CYC = 8
) (
    input  logic          clk,
    input  logic          cancelReset,
    input  logic          coin_valid,
    input  logic [2:0]    coin_code,
    input  logic          sel_valid,
    input  logic [3:0]    sel_idx,
    input  logic          cancel_req,
    output logic [3:0]    price_idx,
    input  logic [CW-1:0] price_data,
    output logic          vend_valid,
    output logic [3:0]    vend_idx,
    input  logic          vend_done,
    output logic          disp_valid,
    output logic [1:0]    disp_coin,
    input  logic          disp_ready,
    output logic          coin_reject,
    output logic [1:0]    sel_error,
    output logic [CW-1:0] credit,
    output logic [CW-1:0] disp_value,
    output logic          busy
);

    localparam int         PW      = $clog2(PREVIEW_CYC + 1);
    localparam logic [CW:0] MAX_SUM = (CW + 1)'(MAX_CREDIT);

    state_t        state;
    logic [CW-1:0] shownValue;
    logic [CW-1:0] changeRem;
    logic [CW-1:0] changeLoadValue;
    logic          changeLoad;
    logic          changeStart;
    logic          changeDone;
    logic          inEntry;
    logic          coinOk;
    logic [CW:0]   coinSum;
    // Preview countdown; stays at zero unless the preview feature loads it.
    logic [PW-1:0] previewCnt;
`ifdef PRICE_PREVIEW_EN
    logic [CW-1:0] previewValue;
`endif

    assign inEntry = (state == IDLE) || (state == CREDIT);
    // One extra bit so an overflowing sum is still compared correctly.
    assign coinSum = {1'b0, credit} + {1'b0, CW'(coinValue(coin_code))};
    assign coinOk  = coin_valid && inEntry && !cancel_req
                     && coinIsValid(coin_code) && (coinSum <= MAX_SUM);
    assign busy    = (state == LOOKUP) || (state == VEND) || (state == CHANGE);

    // Change bookkeeping: load on refund or successful lookup, start on refund or vend_done.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        changeLoad      = 1'b0;
        changeStart     = 1'b0;
        changeLoadValue = credit;
        if (inEntry && cancel_req) begin
            changeLoad  = 1'b1;
            changeStart = 1'b1;
        end else if (state == LOOKUP && price_data != '0 && price_data <= credit
`ifdef PRICE_PREVIEW_EN
                     && credit != '0
`endif
                    ) begin
            changeLoad      = 1'b1;
            changeLoadValue = credit - price_data;
        end else if (state == VEND && vend_done) begin
            changeStart = 1'b1;
        end
    end

    change_unit #(.CW(CW)) u_change (
        .clk        (clk),
        .cancelReset(cancelReset),
        .load       (changeLoad),
        .loadValue  (changeLoadValue),
        .start      (changeStart),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_coin  (disp_coin),
        .remaining  (changeRem),
        .done       (changeDone)
    );

    // Main sequencer: state, credit and all registered strobe/handshake outputs.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge cancelReset) begin
        if (cancelReset) begin
            state       <= IDLE;
            credit      <= '0;
            shownValue  <= '0;
            price_idx   <= '0;
            vend_valid  <= 1'b0;
            vend_idx    <= '0;
            coin_reject <= 1'b0;
            sel_error   <= SEL_NONE;
            previewCnt  <= '0;
`ifdef PRICE_PREVIEW_EN
            previewValue <= '0;
`endif
        end else begin
            coin_reject <= coin_valid && !coinOk;
            sel_error   <= SEL_NONE;
            if (coin_valid) begin
                previewCnt <= '0;
            end else if (previewCnt != '0) begin
                previewCnt <= previewCnt - PW'(1);
            end

            case (state)
                IDLE, CREDIT: begin
                    // cancel_req beats coin_valid beats sel_valid; losers are dropped.
                    if (cancel_req) begin
                        credit <= '0;
                        state  <= CHANGE;
                        if (sel_valid) sel_error <= SEL_INVALID;
                    end else if (coin_valid) begin
                        if (coinOk) begin
                            credit <= coinSum[CW-1:0];
                            state  <= CREDIT;
                        end
                        if (sel_valid) sel_error <= SEL_INVALID;
                    end else if (sel_valid) begin
                        if (sel_idx <= LAST_ITEM) begin
                            price_idx  <= sel_idx;
                            shownValue <= credit;
                            state      <= LOOKUP;
                        end else begin
                            sel_error <= SEL_INVALID;
                        end
                    end
                end
                LOOKUP: begin
                    if (sel_valid) sel_error <= SEL_INVALID;
`ifdef PRICE_PREVIEW_EN
                    if (credit == '0) begin
                        previewValue <= price_data;
                        previewCnt   <= PW'(PREVIEW_CYC);
                        state        <= IDLE;
                    end else
`endif
                    if (price_data == '0) begin
                        sel_error <= SEL_SOLD_OUT;
                        state     <= (credit == '0) ? IDLE : CREDIT;
                    end else if (price_data > credit) begin
                        sel_error <= SEL_INSUFFICIENT;
                        state     <= (credit == '0) ? IDLE : CREDIT;
                    end else begin
                        credit     <= '0;
                        vend_valid <= 1'b1;
                        vend_idx   <= price_idx;
                        state      <= VEND;
                    end
                end
                VEND: begin
                    if (sel_valid) sel_error <= SEL_INVALID;
                    if (vend_done) begin
                        vend_valid <= 1'b0;
                        state      <= CHANGE;
                    end
                end
                CHANGE: begin
                    if (sel_valid) sel_error <= SEL_INVALID;
                    if (changeDone) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display mux: credit while taking money, change while paying, frozen otherwise.
    always_comb begin
        disp_value = shownValue;
        if (inEntry) begin
            disp_value = credit;
        end else if (state == CHANGE) begin
            disp_value = changeRem;
        end
`ifdef PRICE_PREVIEW_EN
        if (state == IDLE && previewCnt != '0) begin
            disp_value = previewValue;
        end
`endif
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: scoreboard bench for vend_controller. Stimulus issues
// one transaction at a time; a reference model keyed on credit in cents
// predicts coin_reject / sel_error / vend / change-coin events into a queue
// that a negedge monitor pops as the DUT presents them.
module tb_vend_controller;

    localparam int CW = 10;
`ifdef PRICE_PREVIEW_EN
    localparam int PREVIEW_WAIT = 12;
`else
    localparam int PREVIEW_WAIT = 0;
`endif

    typedef enum int {EV_REJECT, EV_SELERR, EV_VEND, EV_COIN} evKind_t;
    typedef struct {
        evKind_t kind;
        int      value;
    } evItem_t;

    logic          clk;
    logic          cancelReset;
    logic          coin_valid;
    logic [2:0]    coin_code;
    logic          sel_valid;
    logic [3:0]    sel_idx;
    logic          cancel_req;
    logic [3:0]    price_idx;
    logic [CW-1:0] price_data;
    logic          vend_valid;
    logic [3:0]    vend_idx;
    logic          vend_done;
    logic          disp_valid;
    logic [1:0]    disp_coin;
    logic          disp_ready;
    logic          coin_reject;
    logic [1:0]    sel_error;
    logic [CW-1:0] credit;
    logic [CW-1:0] disp_value;
    logic          busy;

    int      checks = 0;
    int      failures = 0;
    int      modelCredit = 0;
    bit      autoVend = 1;
    bit      autoDisp = 1;
    evItem_t expQ[$];

    vend_controller dut (
        .clk        (clk),
        .cancelReset(cancelReset),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx),
        .cancel_req (cancel_req),
        .price_idx  (price_idx),
        .price_data (price_data),
        .vend_valid (vend_valid),
        .vend_idx   (vend_idx),
        .vend_done  (vend_done),
        .disp_valid (disp_valid),
        .disp_coin  (disp_coin),
        .disp_ready (disp_ready),
        .coin_reject(coin_reject),
        .sel_error  (sel_error),
        .credit     (credit),
        .disp_value (disp_value),
        .busy       (busy)
    );

    // Price table: A1..C3; A2 is sold out.
    function automatic int priceOf(input int idx);
        case (idx)
            0: return 100;
            1: return 0;
            2: return 75;
            3: return 150;
            4: return 225;
            5: return 60;
            6: return 35;
            7: return 325;
            8: return 500;
            default: return 0;
        endcase
    endfunction

    function automatic int coinCents(input int code);
        case (code)
            0: return 5;
            1: return 10;
            2: return 25;
            3: return 50;
            4: return 100;
            5: return 500;
            default: return -1;
        endcase
    endfunction

    assign price_data = CW'(priceOf(int'(price_idx)));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input evKind_t kind, input int value);
        evItem_t e;
        e.kind  = kind;
        e.value = value;
        expQ.push_back(e);
    endtask

    // Greedy payout of an amount as dollar(3) / quarter(2) / dime(1) / nickel(0).
    task automatic pushChange(input int amount);
        int amt = amount;
        while (amt >= 100) begin push(EV_COIN, 3); amt -= 100; end
        while (amt >= 25)  begin push(EV_COIN, 2); amt -= 25;  end
        while (amt >= 10)  begin push(EV_COIN, 1); amt -= 10;  end
        while (amt >= 5)   begin push(EV_COIN, 0); amt -= 5;   end
    endtask

    task automatic strobe(input bit c, input bit [2:0] cc, input bit s, input bit [3:0] si, input bit x);
        coin_valid = c;
        coin_code  = cc;
        sel_valid  = s;
        sel_idx    = si;
        cancel_req = x;
        step();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel_req = 1'b0;
    endtask

    // Predict the events of one transaction issued while idle, then drive it.
    task automatic issue(input bit c, input bit [2:0] cc, input bit s, input bit [3:0] si, input bit x);
        int cents;
        int price;
        if (x) begin
            if (c) push(EV_REJECT, 0);
            if (s) push(EV_SELERR, 3);
            pushChange(modelCredit);
            modelCredit = 0;
        end else if (c) begin
            cents = coinCents(int'(cc));
            if (cents > 0 && modelCredit + cents <= 500) modelCredit += cents;
            else push(EV_REJECT, 0);
            if (s) push(EV_SELERR, 3);
        end else if (s) begin
            price = priceOf(int'(si));
            if (si > 4'd8) begin
                push(EV_SELERR, 3);
            end else if (PREVIEW_WAIT != 0 && modelCredit == 0) begin
                // preview shows the price instead of reporting an error
            end else if (price == 0) begin
                push(EV_SELERR, 1);
            end else if (price > modelCredit) begin
                push(EV_SELERR, 2);
            end else begin
                push(EV_VEND, int'(si));
                pushChange(modelCredit - price);
                modelCredit = 0;
            end
        end
        strobe(c, cc, s, si, x);
    endtask

    // Wait for all predicted events and the return to idle, then compare state.
    task automatic settle();
        int n = 0;
        repeat (2 + PREVIEW_WAIT) step();
        while ((busy || expQ.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("settle_pending_events", expQ.size(), 0);
        check("settle_busy", busy, 0);
        check("credit", int'(credit), modelCredit);
        check("disp_value", int'(disp_value), modelCredit);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_credit"}, int'(credit), 0);
        check({tag, "_disp_value"}, int'(disp_value), 0);
        check({tag, "_vend_valid"}, vend_valid, 0);
        check({tag, "_disp_valid"}, disp_valid, 0);
        check({tag, "_coin_reject"}, coin_reject, 0);
        check({tag, "_sel_error"}, int'(sel_error), 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_price_idx"}, int'(price_idx), 0);
        check({tag, "_vend_idx"}, int'(vend_idx), 0);
    endtask

    task automatic checkEvent(input evKind_t kind, input int value);
        evItem_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%s/%0d required=none", kind.name(), value);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.value != value) begin
                failures++;
                $display("FAIL event actual=%s/%0d required=%s/%0d",
                         kind.name(), value, e.kind.name(), e.value);
            end
        end
    endtask

    // Monitor: compare each DUT-presented event against the scoreboard queue.
    initial begin
        bit prevVend = 1'b0;
        forever begin
            @(negedge clk);
            if (!cancelReset) begin
                if (coin_reject) checkEvent(EV_REJECT, 0);
                if (sel_error != 2'd0) checkEvent(EV_SELERR, int'(sel_error));
                if (vend_valid && !prevVend) checkEvent(EV_VEND, int'(vend_idx));
                if (disp_valid && disp_ready) checkEvent(EV_COIN, int'(disp_coin));
            end
            prevVend = vend_valid;
        end
    end

    // Vend motor model: finishes after a random delay.
    initial begin
        vend_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            vend_done = autoVend && vend_valid && !vend_done && ($urandom_range(0, 3) == 0);
        end
    end

    // Dispenser model: accepts a presented coin after a random delay.
    initial begin
        disp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            disp_ready = autoDisp && disp_valid && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int n;
        coin_valid  = 1'b0;
        coin_code   = 3'd0;
        sel_valid   = 1'b0;
        sel_idx     = 4'd0;
        cancel_req  = 1'b0;
        cancelReset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("reset");
        cancelReset = 1'b0;
        step();

        // Idle selections with no credit: sold out, insufficient, invalid index.
        issue(0, 0, 1, 4'd1, 0);  settle();
        issue(0, 0, 1, 4'd0, 0);  settle();
        issue(0, 0, 1, 4'd12, 0); settle();

        // Four quarters then A1 at exactly the credit: vend, no change.
        repeat (4) begin issue(1, 3'd2, 0, 0, 0); settle(); end
        issue(0, 0, 1, 4'd0, 0); settle();

        // Five-dollar bill, dime over the cap, then B2 with 275 change.
        issue(1, 3'd5, 0, 0, 0); settle();
        issue(1, 3'd1, 0, 0, 0); settle();
        issue(0, 0, 1, 4'd4, 0); settle();

        // Dollar, C2 too expensive, cancel refunds the dollar.
        issue(1, 3'd4, 0, 0, 0); settle();
        issue(0, 0, 1, 4'd7, 0); settle();
        issue(0, 0, 0, 0, 1);    settle();

        // Invalid coin code is always rejected.
        issue(1, 3'd6, 0, 0, 0); settle();

        // Fifty, sold-out A2, then C1 with a coin and a selection thrown in during VEND.
        issue(1, 3'd3, 0, 0, 0); settle();
        issue(0, 0, 1, 4'd1, 0); settle();
        autoVend = 0;
        push(EV_VEND, 6);
        strobe(0, 0, 1, 4'd6, 0);
        n = 0;
        while (!vend_valid && n < 20) begin step(); n++; end
        check("vend_valid_c1", vend_valid, 1);
        push(EV_REJECT, 0);
        strobe(1, 3'd2, 0, 0, 0);
        push(EV_SELERR, 3);
        strobe(0, 0, 1, 4'd0, 0);
        check("credit_during_vend", int'(credit), 0);
        check("vend_idx_held", int'(vend_idx), 6);
        pushChange(15);
        modelCredit = 0;
        autoVend = 1;
        settle();

        // Coin and cancel in the same cycle: coin rejected, quarter refunded.
        issue(1, 3'd2, 0, 0, 0); settle();
        issue(1, 3'd1, 0, 0, 1); settle();

        // Reset while a refund coin is waiting at the dispenser.
        issue(1, 3'd4, 0, 0, 0); settle();
        autoDisp = 0;
        issue(0, 0, 0, 0, 1);
        n = 0;
        while (!disp_valid && n < 20) begin step(); n++; end
        check("disp_valid_before_reset", disp_valid, 1);
        cancelReset = 1'b1;
        #1;
        checkCleared("midchange_reset");
        expQ.delete();
        modelCredit = 0;
        step();
        cancelReset = 1'b0;
        autoDisp = 1;
        step();
        settle();

        // Randomized transactions against the reference model.
        for (int t = 0; t < 250; t++) begin
            int       r;
            bit [2:0] cc;
            bit [3:0] si;
            r  = $urandom_range(0, 99);
            cc = 3'($urandom_range(0, 7));
            si = 4'($urandom_range(0, 10));
            if (r < 45)      issue(1, cc, 0, 0, 0);
            else if (r < 80) issue(0, 0, 1, si, 0);
            else if (r < 90) issue(0, 0, 0, 0, 1);
            else             issue(1'($urandom_range(0, 1)), cc, 1, si, 1'($urandom_range(0, 1)));
            settle();
        end

        check("final_queue_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
